// File: rtl/ibf_cfg_ctrl.sv
// rtl/ibf_cfg_ctrl.sv - config-RAM write controller that drains the datapath before rewriting a mode entry
// Optional IBF_CFG_MODE_FILTER_EN: stall and drain only beats whose mode matches the entry being rewritten.
module ibf_cfg_ctrl #(
  parameter int MODE_WIDTH     = 2,
  parameter int STAGE_NUM_2_2  = 2,
  parameter int CFG_DATA_WIDTH = 8,
  parameter int LATENCY        = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_vld_i,
  output logic                      cfg_rdy_o,
  input  logic [7:0]                cfg_sel_i,
  input  logic [MODE_WIDTH-1:0]     cfg_addr_i,
  input  logic [CFG_DATA_WIDTH-1:0] cfg_data_i,
  input  logic                      dval_i,
  input  logic [MODE_WIDTH-1:0]     mode_i,
  output logic                      in_ready_o,
  output logic                      dval_o,
  output logic [MODE_WIDTH-1:0]     mode_o,
  output logic                      wr_en_2_2_o,
  output logic [7:0]                sram_sel_2_2_o,
  output logic [MODE_WIDTH-1:0]     wr_addr_o,
  output logic [CFG_DATA_WIDTH-1:0] wr_cfg_o,
  output logic                      wr_en_2_1_o,
  output logic                      busy_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, WRITE, SETTLE} state_t;

  localparam logic [7:0] STAGE_LIM = 8'(STAGE_NUM_2_2);
  localparam logic [7:0] MUX_SEL   = 8'hFF;

  state_t                    state_q;
  logic [7:0]                sel_q;
  logic [MODE_WIDTH-1:0]     addr_q;
  logic [CFG_DATA_WIDTH-1:0] data_q;
  logic                      wr_en_2_2_q, wr_en_2_1_q, err_q;
  logic [7:0]                sram_sel_q;
  logic [MODE_WIDTH-1:0]     wr_addr_q, mode_q, mode_d;
  logic [CFG_DATA_WIDTH-1:0] wr_cfg_q;
  logic [LATENCY-1:0]        infl_q, infl_d;
  logic                      take, sel_legal, drain_done, idle;

  assign idle      = (state_q == IDLE);
  assign take      = dval_i & in_ready_o;
  assign sel_legal = (cfg_sel_i < STAGE_LIM) || (cfg_sel_i == MUX_SEL);
  assign mode_d    = take ? mode_i : mode_q;

  // Drain completes on the first cycle whose next in-flight state holds no blocking beat.
  always_comb begin
    infl_d    = '0;
    infl_d[0] = take;
    for (int i = 1; i < LATENCY; i++) infl_d[i] = infl_q[i-1];
  end

`ifdef IBF_CFG_MODE_FILTER_EN
  logic [MODE_WIDTH-1:0] infl_mode_q [LATENCY];
  logic [MODE_WIDTH-1:0] infl_mode_d [LATENCY];

  assign in_ready_o = idle | (mode_i != addr_q);

  always_comb begin
    infl_mode_d[0] = mode_d;
    for (int i = 1; i < LATENCY; i++) infl_mode_d[i] = infl_mode_q[i-1];
    drain_done = 1'b1;
    for (int i = 0; i < LATENCY; i++)
      if (infl_d[i] && (infl_mode_d[i] == addr_q)) drain_done = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) infl_mode_q[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) infl_mode_q[i] <= infl_mode_d[i];
    end
  end
`else
  assign in_ready_o = idle;
  assign drain_done = (infl_d == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q <= '0;
      mode_q <= '0;
    end else begin
      infl_q <= infl_d;
      mode_q <= mode_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_en_2_2_q <= 1'b0;
      wr_en_2_1_q <= 1'b0;
      sram_sel_q  <= '0;
      wr_addr_q   <= '0;
      wr_cfg_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_en_2_2_q <= 1'b0;
      wr_en_2_1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_vld_i) begin
            if (sel_legal) begin
              sel_q   <= cfg_sel_i;
              addr_q  <= cfg_addr_i;
              data_q  <= cfg_data_i;
              state_q <= DRAIN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            wr_en_2_2_q <= (sel_q < STAGE_LIM);
            wr_en_2_1_q <= !(sel_q < STAGE_LIM);
            sram_sel_q  <= sel_q;
            wr_addr_q   <= addr_q;
            wr_cfg_q    <= data_q;
            state_q     <= WRITE;
          end
        end
        WRITE:   state_q <= SETTLE;
        SETTLE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_rdy_o      = idle;
  assign busy_o         = !idle;
  assign err_o          = err_q;
  assign dval_o         = infl_q[0];
  assign mode_o         = mode_q;
  assign wr_en_2_2_o    = wr_en_2_2_q;
  assign wr_en_2_1_o    = wr_en_2_1_q;
  assign sram_sel_2_2_o = sram_sel_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_cfg_o       = wr_cfg_q;

endmodule

// File: tb/tb_ibf_cfg_ctrl.sv
// tb/tb_ibf_cfg_ctrl.sv - directed self-checking bench for ibf_cfg_ctrl
// Filter-specific steps run only when IBF_CFG_MODE_FILTER_EN is defined.
module tb_ibf_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_vld_i;
  logic       cfg_rdy_o;
  logic [7:0] cfg_sel_i;
  logic [1:0] cfg_addr_i;
  logic [7:0] cfg_data_i;
  logic       dval_i;
  logic [1:0] mode_i;
  logic       in_ready_o;
  logic       dval_o;
  logic [1:0] mode_o;
  logic       wr_en_2_2_o;
  logic [7:0] sram_sel_2_2_o;
  logic [1:0] wr_addr_o;
  logic [7:0] wr_cfg_o;
  logic       wr_en_2_1_o;
  logic       busy_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  ibf_cfg_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_vld_i      (cfg_vld_i),
    .cfg_rdy_o      (cfg_rdy_o),
    .cfg_sel_i      (cfg_sel_i),
    .cfg_addr_i     (cfg_addr_i),
    .cfg_data_i     (cfg_data_i),
    .dval_i         (dval_i),
    .mode_i         (mode_i),
    .in_ready_o     (in_ready_o),
    .dval_o         (dval_o),
    .mode_o         (mode_o),
    .wr_en_2_2_o    (wr_en_2_2_o),
    .sram_sel_2_2_o (sram_sel_2_2_o),
    .wr_addr_o      (wr_addr_o),
    .wr_cfg_o       (wr_cfg_o),
    .wr_en_2_1_o    (wr_en_2_1_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [7:0] sel, input logic [1:0] addr, input logic [7:0] data);
    cfg_vld_i  = 1'b1;
    cfg_sel_i  = sel;
    cfg_addr_i = addr;
    cfg_data_i = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_vld_i = 1'b0; cfg_sel_i = '0; cfg_addr_i = '0; cfg_data_i = '0;
    dval_i = 1'b0; mode_i = '0;
    repeat (2) tick();
    check("rst_cfg_rdy", cfg_rdy_o, 1);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_dval", dval_o, 0);
    check("rst_mode", mode_o, 0);
    check("rst_wr22", wr_en_2_2_o, 0);
    check("rst_wr21", wr_en_2_1_o, 0);
    check("rst_sel", sram_sel_2_2_o, 0);
    check("rst_addr", wr_addr_o, 0);
    check("rst_cfg", wr_cfg_o, 0);
    rst = 1'b0;
    tick();

    // Idle request, no traffic: 1-cycle drain, write, settle
    request(8'd1, 2'd2, 8'hA5);
    #1 check("t1_rdy_idle", cfg_rdy_o, 1);
    tick();
    cfg_vld_i = 1'b0;
    check("t1_drain_busy", busy_o, 1);
    check("t1_drain_rdy", cfg_rdy_o, 0);
    check("t1_drain_wr22", wr_en_2_2_o, 0);
    tick();
    check("t1_wr22", wr_en_2_2_o, 1);
    check("t1_wr21", wr_en_2_1_o, 0);
    check("t1_sel", sram_sel_2_2_o, 1);
    check("t1_addr", wr_addr_o, 2);
    check("t1_cfg", wr_cfg_o, 8'hA5);
    check("t1_write_busy", busy_o, 1);
    tick();
    check("t1_settle_wr22", wr_en_2_2_o, 0);
    check("t1_settle_busy", busy_o, 1);
    check("t1_hold_cfg", wr_cfg_o, 8'hA5);
    tick();
    check("t1_idle_busy", busy_o, 0);
    check("t1_idle_rdy", cfg_rdy_o, 1);

    // Continuous beats, then a 2:1 mux request accepted alongside a beat
    dval_i = 1'b1; mode_i = 2'd2;
    tick(); tick();
    check("t2_dval", dval_o, 1);
    check("t2_mode2", mode_o, 2);
    mode_i = 2'd0;
    tick(); tick(); tick();
    check("t2_mode0", mode_o, 0);
    request(8'hFF, 2'd0, 8'h3C);
    tick();
    cfg_vld_i = 1'b0;
    check("t2_c0_last_dval", dval_o, 1);
    check("t2_c0_busy", busy_o, 1);
    #1 check("t2_c0_in_ready", in_ready_o, 0);
    tick();
    check("t2_c1_dval", dval_o, 0);
    check("t2_c1_wr21", wr_en_2_1_o, 0);
    tick();
    check("t2_c2_wr21", wr_en_2_1_o, 0);
    tick();
    check("t2_c3_wr21", wr_en_2_1_o, 1);
    check("t2_c3_wr22", wr_en_2_2_o, 0);
    check("t2_c3_sel", sram_sel_2_2_o, 8'hFF);
    check("t2_c3_addr", wr_addr_o, 0);
    check("t2_c3_cfg", wr_cfg_o, 8'h3C);
    tick();
    check("t2_c4_wr21", wr_en_2_1_o, 0);
    check("t2_c4_in_ready", in_ready_o, 0);
    check("t2_c4_busy", busy_o, 1);
    tick();
    check("t2_c5_busy", busy_o, 0);
    check("t2_c5_in_ready", in_ready_o, 1);
    check("t2_c5_dval", dval_o, 0);
    tick();
    check("t2_c6_dval", dval_o, 1);
    dval_i = 1'b0; mode_i = 2'd1;
    tick(); tick();
    check("t2_dval_off", dval_o, 0);
    check("t2_mode_hold", mode_o, 0);

    // Illegal selects: sticky error, no write, stays idle
    request(8'h05, 2'd1, 8'h99);
    #1 check("t3_rdy", cfg_rdy_o, 1);
    tick();
    check("t3_err", err_o, 1);
    check("t3_busy", busy_o, 0);
    check("t3_rdy_after", cfg_rdy_o, 1);
    cfg_sel_i = 8'd2;
    tick();
    check("t3_sel2_busy", busy_o, 0);
    cfg_vld_i = 1'b0;
    tick();
    check("t3_wr22", wr_en_2_2_o, 0);
    check("t3_wr21", wr_en_2_1_o, 0);
    check("t3_err_sticky", err_o, 1);
    check("t3_cfg_hold", wr_cfg_o, 8'h3C);

    // Request held while busy is not re-accepted; sel=0 is the lowest stage
    request(8'd0, 2'd3, 8'h11);
    tick();
    check("t4_c0_rdy", cfg_rdy_o, 0);
    check("t4_c0_busy", busy_o, 1);
    tick();
    cfg_vld_i = 1'b0;
    check("t4_wr22", wr_en_2_2_o, 1);
    check("t4_sel", sram_sel_2_2_o, 0);
    check("t4_addr", wr_addr_o, 3);
    check("t4_cfg", wr_cfg_o, 8'h11);
    tick(); tick();
    check("t4_idle", busy_o, 0);

    // Reset during DRAIN aborts the write
    dval_i = 1'b1; mode_i = 2'd1;
    tick(); tick(); tick();
    request(8'd1, 2'd1, 8'h77);
    tick();
    cfg_vld_i = 1'b0;
    check("t5_drain_busy", busy_o, 1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_rdy", cfg_rdy_o, 1);
    check("t5_rst_in_ready", in_ready_o, 1);
    check("t5_rst_dval", dval_o, 0);
    check("t5_rst_mode", mode_o, 0);
    check("t5_rst_err", err_o, 0);
    check("t5_rst_wr22", wr_en_2_2_o, 0);
    check("t5_rst_wr21", wr_en_2_1_o, 0);
    check("t5_rst_sel", sram_sel_2_2_o, 0);
    check("t5_rst_addr", wr_addr_o, 0);
    check("t5_rst_cfg", wr_cfg_o, 0);
    dval_i = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_wr22", wr_en_2_2_o, 0);
      check("t5_no_busy", busy_o, 0);
    end
    request(8'd0, 2'd2, 8'h5A);
    tick();
    cfg_vld_i = 1'b0;
    tick();
    check("t5_wr22", wr_en_2_2_o, 1);
    check("t5_addr", wr_addr_o, 2);
    check("t5_cfg", wr_cfg_o, 8'h5A);
    tick(); tick();
    check("t5_idle", busy_o, 0);

`ifdef IBF_CFG_MODE_FILTER_EN
    // Mode filter: beats of other modes pass while the addressed mode is stalled
    dval_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mode_i = 2'(i % 2);
      tick();
    end
    request(8'd0, 2'd1, 8'h42);
    tick();
    cfg_vld_i = 1'b0;
    mode_i = 2'd0;
    #1 check("f_in_ready_m0", in_ready_o, 1);
    tick();
    check("f_dval_m0", dval_o, 1);
    check("f_mode_m0", mode_o, 0);
    mode_i = 2'd1;
    #1 check("f_in_ready_m1", in_ready_o, 0);
    tick();
    check("f_dval_stalled", dval_o, 0);
    begin
      int n;
      n = 0;
      while (busy_o && n < 20) begin
        tick();
        n++;
      end
    end
    check("f_back_idle", busy_o, 0);
    tick();
    check("f_dval_m1", dval_o, 1);
    check("f_mode_m1", mode_o, 1);
    dval_i = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
